// File: rtl/mips_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control path: opcodes, ALU-op
// codes, FSM state encodings, instruction classes and datapath mux selects.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [3:0] ALU_ADDI  = 4'b0000;
    localparam logic [3:0] ALU_ORI   = 4'b0001;
    localparam logic [3:0] ALU_LUI   = 4'b0010;
    localparam logic [3:0] ALU_ANDI  = 4'b0011;
    localparam logic [3:0] ALU_LW    = 4'b0100;
    localparam logic [3:0] ALU_SW    = 4'b0101;
    localparam logic [3:0] ALU_BEQ   = 4'b0110;
    localparam logic [3:0] ALU_BNE   = 4'b0111;
    localparam logic [3:0] ALU_J     = 4'b1000;
    localparam logic [3:0] ALU_JAL   = 4'b1001;
    localparam logic [3:0] ALU_RTYPE = 4'b1111;
    localparam logic [3:0] ALU_NONE  = 4'b0000;

    localparam logic [3:0] S_IDLE       = 4'd0;
    localparam logic [3:0] S_FETCH      = 4'd1;
    localparam logic [3:0] S_DECODE     = 4'd2;
    localparam logic [3:0] S_EXECUTE    = 4'd3;
    localparam logic [3:0] S_ALU_WB     = 4'd4;
    localparam logic [3:0] S_MEM_ADDR   = 4'd5;
    localparam logic [3:0] S_MEM_ACCESS = 4'd6;
    localparam logic [3:0] S_MEM_WB     = 4'd7;
    localparam logic [3:0] S_BRANCH     = 4'd8;
    localparam logic [3:0] S_JUMP       = 4'd9;
    localparam logic [3:0] S_JR_EXEC    = 4'd10;
    localparam logic [3:0] S_ILLEGAL    = 4'd11;

    typedef enum logic [3:0] {
        CLS_R, CLS_JR, CLS_IALU, CLS_LW, CLS_SW,
        CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL, CLS_BAD
    } instr_class_t;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_REGA   = 2'b11;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] RDST_RT = 2'b00;
    localparam logic [1:0] RDST_RD = 2'b01;
    localparam logic [1:0] RDST_RA = 2'b10;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle between the control FSM (master) and the datapath/memory (slave).
interface multicycle_control_if #(parameter int CNT_WIDTH = 32);
    logic [5:0]           opcode_i;
    logic [5:0]           function_i;
    logic                 mem_ack_i;
    logic                 mem_read_o;
    logic                 mem_write_o;
    logic                 i_or_d_o;
    logic                 ir_write_o;
    logic                 pc_write_o;
    logic                 pc_write_cond_o;
    logic                 branch_ne_o;
    logic [1:0]           pc_source_o;
    logic                 alu_src_a_o;
    logic [1:0]           alu_src_b_o;
    logic [3:0]           alu_op_o;
    logic                 reg_write_o;
    logic [1:0]           reg_dst_o;
    logic [1:0]           mem_to_reg_o;
    logic                 illegal_o;
    logic [CNT_WIDTH-1:0] retired_o;

    modport master (
        input  opcode_i, function_i, mem_ack_i,
        output mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o,
               pc_write_cond_o, branch_ne_o, pc_source_o, alu_src_a_o,
               alu_src_b_o, alu_op_o, reg_write_o, reg_dst_o, mem_to_reg_o,
               illegal_o, retired_o
    );

    modport slave (
        output opcode_i, function_i, mem_ack_i,
        input  mem_read_o, mem_write_o, i_or_d_o, ir_write_o, pc_write_o,
               pc_write_cond_o, branch_ne_o, pc_source_o, alu_src_a_o,
               alu_src_b_o, alu_op_o, reg_write_o, reg_dst_o, mem_to_reg_o,
               illegal_o, retired_o
    );
endinterface

// File: rtl/control_opcode_decoder.sv
// Combinational opcode/funct lookup: instruction class plus its ALU-op code.
module control_opcode_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   function_code,
    output instr_class_t cls,
    output logic [3:0]   alu_op
);

    // Map opcode (and funct for JR) to class and ALU-op; unknown opcodes are CLS_BAD.
    always_comb begin
        cls    = CLS_BAD;
        alu_op = ALU_NONE;
        case (opcode)
            OP_RTYPE: begin
                cls    = (function_code == FN_JR) ? CLS_JR : CLS_R;
                alu_op = ALU_RTYPE;
            end
            OP_ADDI: begin cls = CLS_IALU; alu_op = ALU_ADDI; end
            OP_ORI:  begin cls = CLS_IALU; alu_op = ALU_ORI;  end
            OP_ANDI: begin cls = CLS_IALU; alu_op = ALU_ANDI; end
            OP_LUI:  begin cls = CLS_IALU; alu_op = ALU_LUI;  end
            OP_LW:   begin cls = CLS_LW;   alu_op = ALU_LW;   end
            OP_SW:   begin cls = CLS_SW;   alu_op = ALU_SW;   end
            OP_BEQ:  begin cls = CLS_BEQ;  alu_op = ALU_BEQ;  end
            OP_BNE:  begin cls = CLS_BNE;  alu_op = ALU_BNE;  end
            OP_J:    begin cls = CLS_J;    alu_op = ALU_J;    end
            OP_JAL:  begin cls = CLS_JAL;  alu_op = ALU_JAL;  end
            default: begin cls = CLS_BAD;  alu_op = ALU_NONE; end
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath.
//
// state      | meaning
// IDLE       | post-reset, all strobes off
// FETCH      | read instruction at PC, PC+4 on ack
// DECODE     | branch target into ALUOut, dispatch on class
// EXECUTE    | R-type / immediate ALU operation
// ALU_WB     | ALUOut to register file
// MEM_ADDR   | effective address for LW/SW
// MEM_ACCESS | data read/write, wait for ack
// MEM_WB     | MDR to register file
// BRANCH     | BEQ/BNE compare and conditional PC load
// JUMP       | J/JAL (JAL links PC into $31)
// JR_EXEC    | PC <- register A
// ILLEGAL    | bad opcode or memory timeout, held until reset
module multicycle_control #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_WIDTH      = 32
) (
    input logic                  clk,
    input logic                  reset,
    multicycle_control_if.master bus
);
    import mips_ctrl_pkg::*;

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LIMIT = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    logic [3:0]           state, state_next;
    logic [TW-1:0]        wait_cnt;
    logic [CNT_WIDTH-1:0] retired;
    instr_class_t         cls;
    logic [3:0]           dec_alu_op;
    logic                 waiting, timeout_hit, retire;

    control_opcode_decoder u_dec (
        .opcode        (bus.opcode_i),
        .function_code (bus.function_i),
        .cls           (cls),
        .alu_op        (dec_alu_op)
    );

    assign waiting     = (state == S_FETCH) || (state == S_MEM_ACCESS);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && waiting && !bus.mem_ack_i && (wait_cnt == LIMIT);
    // Every path back into FETCH except from IDLE or FETCH itself completes an instruction.
    assign retire      = (state_next == S_FETCH) && (state != S_FETCH) && (state != S_IDLE);

    // Next-state selection.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:    state_next = S_FETCH;
            S_FETCH: begin
                if (bus.mem_ack_i)    state_next = S_DECODE;
                else if (timeout_hit) state_next = S_ILLEGAL;
            end
            S_DECODE: begin
                case (cls)
                    CLS_JR:                state_next = S_JR_EXEC;
                    CLS_R, CLS_IALU:       state_next = S_EXECUTE;
                    CLS_LW, CLS_SW:        state_next = S_MEM_ADDR;
                    CLS_BEQ, CLS_BNE:      state_next = S_BRANCH;
                    CLS_J, CLS_JAL:        state_next = S_JUMP;
                    default:               state_next = S_ILLEGAL;
                endcase
            end
            S_EXECUTE:  state_next = S_ALU_WB;
            S_MEM_ADDR: state_next = S_MEM_ACCESS;
            S_MEM_ACCESS: begin
                if (bus.mem_ack_i)    state_next = (cls == CLS_SW) ? S_FETCH : S_MEM_WB;
                else if (timeout_hit) state_next = S_ILLEGAL;
            end
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP, S_JR_EXEC: state_next = S_FETCH;
            S_ILLEGAL:  state_next = S_ILLEGAL;
            default:    state_next = S_ILLEGAL;
        endcase
    end

    // State, wait timer and retired-instruction counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            retired  <= '0;
        end else begin
            state <= state_next;
            if (waiting && !bus.mem_ack_i && state_next == state)
                wait_cnt <= wait_cnt + TW'(1);
            else
                wait_cnt <= '0;
            if (retire)
                retired <= retired + CNT_WIDTH'(1);
        end
    end

    // Datapath strobes decoded from the current state and instruction class.
    always_comb begin
        bus.mem_read_o      = 1'b0;
        bus.mem_write_o     = 1'b0;
        bus.i_or_d_o        = 1'b0;
        bus.ir_write_o      = 1'b0;
        bus.pc_write_o      = 1'b0;
        bus.pc_write_cond_o = 1'b0;
        bus.branch_ne_o     = 1'b0;
        bus.pc_source_o     = PCS_ALU;
        bus.alu_src_a_o     = 1'b0;
        bus.alu_src_b_o     = SRCB_B;
        bus.alu_op_o        = ALU_NONE;
        bus.reg_write_o     = 1'b0;
        bus.reg_dst_o       = RDST_RT;
        bus.mem_to_reg_o    = M2R_ALUOUT;
        bus.illegal_o       = 1'b0;
        case (state)
            S_FETCH: begin
                bus.mem_read_o  = 1'b1;
                bus.alu_src_b_o = SRCB_FOUR;
                bus.ir_write_o  = bus.mem_ack_i;
                bus.pc_write_o  = bus.mem_ack_i;
            end
            S_DECODE:   bus.alu_src_b_o = SRCB_IMM_SH2;
            S_EXECUTE: begin
                bus.alu_src_a_o = 1'b1;
                bus.alu_src_b_o = (cls == CLS_R) ? SRCB_B : SRCB_IMM;
                bus.alu_op_o    = dec_alu_op;
            end
            S_ALU_WB: begin
                bus.reg_write_o = 1'b1;
                bus.reg_dst_o   = (cls == CLS_R) ? RDST_RD : RDST_RT;
            end
            S_MEM_ADDR: begin
                bus.alu_src_a_o = 1'b1;
                bus.alu_src_b_o = SRCB_IMM;
                bus.alu_op_o    = dec_alu_op;
            end
            S_MEM_ACCESS: begin
                bus.i_or_d_o    = 1'b1;
                bus.mem_read_o  = (cls != CLS_SW);
                bus.mem_write_o = (cls == CLS_SW);
            end
            S_MEM_WB: begin
                bus.reg_write_o  = 1'b1;
                bus.mem_to_reg_o = M2R_MDR;
            end
            S_BRANCH: begin
                bus.alu_src_a_o     = 1'b1;
                bus.alu_op_o        = dec_alu_op;
                bus.pc_write_cond_o = 1'b1;
                bus.pc_source_o     = PCS_ALUOUT;
                bus.branch_ne_o     = (cls == CLS_BNE);
            end
            S_JUMP: begin
                bus.pc_write_o  = 1'b1;
                bus.pc_source_o = PCS_JUMP;
                bus.alu_op_o    = dec_alu_op;
                if (cls == CLS_JAL) begin
                    bus.reg_write_o  = 1'b1;
                    bus.reg_dst_o    = RDST_RA;
                    bus.mem_to_reg_o = M2R_PC;
                end
            end
            S_JR_EXEC: begin
                bus.pc_write_o  = 1'b1;
                bus.pc_source_o = PCS_REGA;
                bus.alu_op_o    = ALU_RTYPE;
            end
            S_ILLEGAL:  bus.illegal_o = 1'b1;
            default: ;
        endcase
    end

    assign bus.retired_o = retired;

endmodule
